roce_wr_scheduler: RTL and testbench

Sits directly upstream of the QP state module on the transmit path. It accepts one work request (WR) at a time and fetches the QP context for the WR's local QPN through the QP state module's context-read port. It then expands the WR into s_n_transfers per-transfer DMA commands for the TX header/DMA engine. Each command carries the remote address, length, start PSN and packet count.

---
 rtl/roce_pkg.sv | 50 +++++
 rtl/roce_pkt_count.sv | 32 +++
 rtl/roce_wr_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_roce_wr_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_pkg.sv
// Shared RoCE transmit-path definitions: PMTU encodings, RC opcodes, QPN window
// and PSN width, plus the scheduler state encoding.
package roce_pkg;

    localparam int          PSN_W    = 24;
    localparam logic [23:0] QPN_BASE = 24'h000100;

    typedef enum logic [2:0] {
        PMTU_256  = 3'd0,
        PMTU_512  = 3'd1,
        PMTU_1024 = 3'd2,
        PMTU_2048 = 3'd3,
        PMTU_4096 = 3'd4
    } pmtu_e;

    localparam logic [7:0] RC_SEND_FIRST          = 8'h00;
    localparam logic [7:0] RC_SEND_MIDDLE         = 8'h01;
    localparam logic [7:0] RC_SEND_LAST           = 8'h02;
    localparam logic [7:0] RC_SEND_LAST_IMM       = 8'h03;
    localparam logic [7:0] RC_SEND_ONLY           = 8'h04;
    localparam logic [7:0] RC_SEND_ONLY_IMM       = 8'h05;
    localparam logic [7:0] RC_RDMA_WRITE_FIRST    = 8'h06;
    localparam logic [7:0] RC_RDMA_WRITE_MIDDLE   = 8'h07;
    localparam logic [7:0] RC_RDMA_WRITE_LAST     = 8'h08;
    localparam logic [7:0] RC_RDMA_WRITE_LAST_IMM = 8'h09;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY     = 8'h0A;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY_IMM = 8'h0B;
    localparam logic [7:0] RC_ACK                 = 8'h11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTX_REQ,
        ST_CTX_WAIT,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } wr_state_e;

    // Encodings above 4096 saturate to the largest supported PMTU.
    function automatic logic [3:0] pmtu_shift(input logic [2:0] pmtu);
        case (pmtu)
            3'd0:    return 4'd8;
            3'd1:    return 4'd9;
            3'd2:    return 4'd10;
            3'd3:    return 4'd11;
            default: return 4'd12;
        endcase
    endfunction

endpackage

// File: rtl/roce_pkt_count.sv
// Registered packet count for one transfer: ceil(length / PMTU), minimum 1.
module roce_pkt_count
    import roce_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] length,
    input  logic [2:0]  pmtu,
    output logic [24:0] n_pkts
);

    logic [3:0]  shift;
    logic [32:0] sum;
    logic [24:0] n_pkts_d;
    logic [24:0] n_pkts_q;

    always_comb begin
        shift = pmtu_shift(pmtu);
        sum   = {1'b0, length} + ((33'd1 << shift) - 33'd1);
        if (length == 32'd0) begin
            n_pkts_d = 25'd1;
        end else begin
            n_pkts_d = 25'(sum >> shift);
        end
    end

    always_ff @(posedge clk) begin
        n_pkts_q <= n_pkts_d;
    end

    assign n_pkts = n_pkts_q;

endmodule

// File: rtl/roce_wr_scheduler.sv
// Work-request scheduler: fetches the QP context for a WR and expands it into
// per-transfer DMA commands for the TX header/DMA engine.
module roce_wr_scheduler
    import roce_pkg::*;
#(
    parameter int CTX_TIMEOUT     = 8,
    parameter int MAX_QUEUE_PAIRS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_wr_valid,
    output logic        s_wr_ready,
    input  logic        s_tx_type,
    input  logic        s_is_immediate,
    input  logic [23:0] s_loc_qpn,
    input  logic [63:0] s_rem_addr_offset,
    input  logic [31:0] s_dma_length,
    input  logic [31:0] s_n_transfers,
    output logic        qp_context_req,
    output logic [23:0] qp_local_qpn_req,
    input  logic        qp_req_context_valid,
    input  logic [31:0] qp_req_r_key,
    input  logic [23:0] qp_req_rem_qpn,
    input  logic [23:0] qp_req_rem_psn,
    input  logic [31:0] qp_req_rem_ip_addr,
    input  logic [63:0] qp_req_rem_addr,
    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    output logic        m_cmd_tx_type,
    output logic        m_cmd_is_immediate,
    output logic        m_cmd_last,
    output logic [23:0] m_cmd_loc_qpn,
    output logic [23:0] m_cmd_rem_qpn,
    output logic [31:0] m_cmd_rem_ip_addr,
    output logic [31:0] m_cmd_r_key,
    output logic [63:0] m_cmd_rem_addr,
    output logic [31:0] m_cmd_length,
    output logic [23:0] m_cmd_start_psn,
    output logic [24:0] m_cmd_n_pkts,
    input  logic        stop_transfer,
    input  logic [2:0]  pmtu,
    output logic        wr_done,
    output logic        wr_error,
    output logic        busy
);

    localparam int TMR_W = $clog2(CTX_TIMEOUT + 1);

    if (CTX_TIMEOUT < 1 || MAX_QUEUE_PAIRS < 1) begin : g_param_check
        $error("roce_wr_scheduler: CTX_TIMEOUT and MAX_QUEUE_PAIRS must be at least 1");
    end

    wr_state_e   state_d, state_q;
    logic [TMR_W-1:0] timer_d, timer_q;
    logic [31:0] cnt_d, cnt_q;
    logic        arm_d, arm_q;
    logic        hold_d, hold_q;

    logic        tx_type_d, tx_type_q;
    logic        imm_d, imm_q;
    logic [23:0] loc_qpn_d, loc_qpn_q;
    logic [63:0] offset_d, offset_q;
    logic [31:0] len_d, len_q;
    logic [31:0] ntr_d, ntr_q;
    logic [2:0]  pmtu_d, pmtu_q;

    logic [31:0] r_key_d, r_key_q;
    logic [23:0] rem_qpn_d, rem_qpn_q;
    logic [31:0] ip_d, ip_q;
    logic [63:0] addr_d, addr_q;
    logic [23:0] psn_d, psn_q;

    logic [24:0] n_pkts;
    logic        cmd_valid;
    logic        cmd_last;
    logic        cmd_fire;

    roce_pkt_count u_pkt_count (
        .clk    (clk),
        .length (len_q),
        .pmtu   (pmtu_q),
        .n_pkts (n_pkts)
    );

    // A command may only launch while stop_transfer is low; once up it is held
    // by hold_q until accepted. arm_q spends one ISSUE cycle before the first launch.
    assign cmd_last  = (cnt_q == (ntr_q - 32'd1));
    assign cmd_valid = (state_q == ST_ISSUE) && (hold_q || (arm_q && !stop_transfer));
    assign cmd_fire  = cmd_valid && m_cmd_ready;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        arm_d     = 1'b0;
        hold_d    = 1'b0;
        tx_type_d = tx_type_q;
        imm_d     = imm_q;
        loc_qpn_d = loc_qpn_q;
        offset_d  = offset_q;
        len_d     = len_q;
        ntr_d     = ntr_q;
        pmtu_d    = pmtu_q;
        r_key_d   = r_key_q;
        rem_qpn_d = rem_qpn_q;
        ip_d      = ip_q;
        addr_d    = addr_q;
        psn_d     = psn_q;

        case (state_q)
            ST_IDLE: begin
                if (s_wr_valid) begin
                    tx_type_d = s_tx_type;
                    imm_d     = s_is_immediate;
                    loc_qpn_d = s_loc_qpn;
                    offset_d  = s_rem_addr_offset;
                    len_d     = s_dma_length;
                    ntr_d     = s_n_transfers;
                    pmtu_d    = pmtu;
                    state_d   = ST_CTX_REQ;
                end
            end
            ST_CTX_REQ: begin
                timer_d = '0;
                state_d = ST_CTX_WAIT;
            end
            ST_CTX_WAIT: begin
                if (qp_req_context_valid) begin
                    r_key_d   = qp_req_r_key;
                    rem_qpn_d = qp_req_rem_qpn;
                    ip_d      = qp_req_rem_ip_addr;
                    addr_d    = qp_req_rem_addr + offset_q;
                    psn_d     = qp_req_rem_psn;
                    cnt_d     = 32'd0;
                    state_d   = (ntr_q == 32'd0) ? ST_DONE : ST_ISSUE;
                end else if (timer_q == TMR_W'(CTX_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_ISSUE: begin
                arm_d  = 1'b1;
                hold_d = cmd_valid && !m_cmd_ready;
                if (cmd_fire) begin
                    addr_d = addr_q + {32'd0, len_q};
                    psn_d  = psn_q + n_pkts[PSN_W-1:0];
                    cnt_d  = cnt_q + 32'd1;
                    if (cmd_last) begin
                        arm_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            hold_q  <= hold_d;
        end
    end

    // WR and context fields carry no reset; every output using them is gated.
    always_ff @(posedge clk) begin
        tx_type_q <= tx_type_d;
        imm_q     <= imm_d;
        loc_qpn_q <= loc_qpn_d;
        offset_q  <= offset_d;
        len_q     <= len_d;
        ntr_q     <= ntr_d;
        pmtu_q    <= pmtu_d;
        r_key_q   <= r_key_d;
        rem_qpn_q <= rem_qpn_d;
        ip_q      <= ip_d;
        addr_q    <= addr_d;
        psn_q     <= psn_d;
    end

    assign s_wr_ready       = (state_q == ST_IDLE);
    assign qp_context_req   = (state_q == ST_CTX_REQ);
    assign qp_local_qpn_req = qp_context_req ? loc_qpn_q : 24'd0;
    assign wr_done          = (state_q == ST_DONE);
    assign wr_error         = (state_q == ST_ERR);
    assign busy             = (state_q != ST_IDLE);

    assign m_cmd_valid        = cmd_valid;
    assign m_cmd_tx_type      = cmd_valid & tx_type_q;
    assign m_cmd_is_immediate = cmd_valid & cmd_last & imm_q;
    assign m_cmd_last         = cmd_valid & cmd_last;
    assign m_cmd_loc_qpn      = cmd_valid ? loc_qpn_q : 24'd0;
    assign m_cmd_rem_qpn      = cmd_valid ? rem_qpn_q : 24'd0;
    assign m_cmd_rem_ip_addr  = cmd_valid ? ip_q      : 32'd0;
    assign m_cmd_r_key        = cmd_valid ? r_key_q   : 32'd0;
    assign m_cmd_rem_addr     = cmd_valid ? addr_q    : 64'd0;
    assign m_cmd_length       = cmd_valid ? len_q     : 32'd0;
    assign m_cmd_start_psn    = cmd_valid ? psn_q     : 24'd0;
    assign m_cmd_n_pkts       = cmd_valid ? n_pkts    : 25'd0;

endmodule

// File: tb/tb_roce_wr_scheduler.sv
// Directed bench for roce_wr_scheduler: table of WRs with hand-computed command
// fields, plus sequences for n=0, context timeout, backpressure and mid-WR reset.
module tb_roce_wr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_wr_valid, s_wr_ready, s_tx_type, s_is_immediate;
    logic [23:0] s_loc_qpn;
    logic [63:0] s_rem_addr_offset;
    logic [31:0] s_dma_length, s_n_transfers;
    logic        qp_context_req;
    logic [23:0] qp_local_qpn_req;
    logic        qp_req_context_valid;
    logic [31:0] qp_req_r_key;
    logic [23:0] qp_req_rem_qpn, qp_req_rem_psn;
    logic [31:0] qp_req_rem_ip_addr;
    logic [63:0] qp_req_rem_addr;
    logic        m_cmd_valid, m_cmd_ready, m_cmd_tx_type, m_cmd_is_immediate, m_cmd_last;
    logic [23:0] m_cmd_loc_qpn, m_cmd_rem_qpn, m_cmd_start_psn;
    logic [31:0] m_cmd_rem_ip_addr, m_cmd_r_key, m_cmd_length;
    logic [63:0] m_cmd_rem_addr;
    logic [24:0] m_cmd_n_pkts;
    logic        stop_transfer;
    logic [2:0]  pmtu;
    logic        wr_done, wr_error, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    roce_wr_scheduler #(.CTX_TIMEOUT(8), .MAX_QUEUE_PAIRS(4)) dut (
        .clk(clk), .rst(rst),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_tx_type(s_tx_type),
        .s_is_immediate(s_is_immediate), .s_loc_qpn(s_loc_qpn),
        .s_rem_addr_offset(s_rem_addr_offset), .s_dma_length(s_dma_length),
        .s_n_transfers(s_n_transfers),
        .qp_context_req(qp_context_req), .qp_local_qpn_req(qp_local_qpn_req),
        .qp_req_context_valid(qp_req_context_valid), .qp_req_r_key(qp_req_r_key),
        .qp_req_rem_qpn(qp_req_rem_qpn), .qp_req_rem_psn(qp_req_rem_psn),
        .qp_req_rem_ip_addr(qp_req_rem_ip_addr), .qp_req_rem_addr(qp_req_rem_addr),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_tx_type(m_cmd_tx_type),
        .m_cmd_is_immediate(m_cmd_is_immediate), .m_cmd_last(m_cmd_last),
        .m_cmd_loc_qpn(m_cmd_loc_qpn), .m_cmd_rem_qpn(m_cmd_rem_qpn),
        .m_cmd_rem_ip_addr(m_cmd_rem_ip_addr), .m_cmd_r_key(m_cmd_r_key),
        .m_cmd_rem_addr(m_cmd_rem_addr), .m_cmd_length(m_cmd_length),
        .m_cmd_start_psn(m_cmd_start_psn), .m_cmd_n_pkts(m_cmd_n_pkts),
        .stop_transfer(stop_transfer), .pmtu(pmtu),
        .wr_done(wr_done), .wr_error(wr_error), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // QP state module stand-in: answers QPNs 0x100..0x103 two cycles after the request.
    logic rq_d1, rq_d2;
    initial begin
        rq_d1 = 1'b0;
        rq_d2 = 1'b0;
        qp_req_context_valid = 1'b0;
        forever begin
            @(negedge clk);
            qp_req_context_valid = rq_d2;
            rq_d2 = rq_d1;
            rq_d1 = qp_context_req && (qp_local_qpn_req >= 24'h100) && (qp_local_qpn_req < 24'h104);
        end
    end

    typedef struct {
        logic [23:0] qpn;
        logic        tx_type;
        logic        imm;
        logic [2:0]  pmtu;
        logic [31:0] len;
        logic [31:0] ntr;
        logic [63:0] off;
        logic [63:0] ctx_addr;
        logic [23:0] ctx_psn;
        logic [24:0] exp_npk;
        logic [63:0] exp_addr0;
        logic [23:0] exp_psn0;
        logic [63:0] exp_addr_last;
        logic [23:0] exp_psn_last;
    } vec_t;

    vec_t vecs[5];

    task automatic drive_wr(input vec_t v);
        s_loc_qpn         = v.qpn;
        s_tx_type         = v.tx_type;
        s_is_immediate    = v.imm;
        pmtu              = v.pmtu;
        s_dma_length      = v.len;
        s_n_transfers     = v.ntr;
        s_rem_addr_offset = v.off;
        qp_req_rem_addr   = v.ctx_addr;
        qp_req_rem_psn    = v.ctx_psn;
        s_wr_valid        = 1'b1;
    endtask

    // Called just after a negedge with the DUT idle and m_cmd_ready = 1.
    task automatic run_wr(input vec_t v, input string tag);
        int k;
        int waitc;
        drive_wr(v);
        chk({tag, "_wr_ready"}, 64'(s_wr_ready), 64'd1);
        @(negedge clk);
        s_wr_valid = 1'b0;
        k = 1;
        chk({tag, "_ctx_req"}, 64'(qp_context_req), 64'd1);
        chk({tag, "_ctx_qpn"}, 64'(qp_local_qpn_req), 64'(v.qpn));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        waitc = 0;
        while (!m_cmd_valid && waitc < 20) begin
            @(negedge clk);
            k++;
            waitc++;
        end
        chk({tag, "_first_latency"}, 64'(k), 64'd5);
        for (int i = 0; i < int'(v.ntr); i++) begin
            waitc = 0;
            while (!m_cmd_valid && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            if (!m_cmd_valid) begin
                chk({tag, "_cmd_timeout"}, 64'(m_cmd_valid), 64'd1);
                return;
            end
            if (i == 0) begin
                chk({tag, "_addr0"}, m_cmd_rem_addr, v.exp_addr0);
                chk({tag, "_psn0"}, 64'(m_cmd_start_psn), 64'(v.exp_psn0));
                chk({tag, "_npk0"}, 64'(m_cmd_n_pkts), 64'(v.exp_npk));
                chk({tag, "_len0"}, 64'(m_cmd_length), 64'(v.len));
                chk({tag, "_type0"}, 64'(m_cmd_tx_type), 64'(v.tx_type));
                chk({tag, "_locqpn0"}, 64'(m_cmd_loc_qpn), 64'(v.qpn));
                chk({tag, "_remqpn0"}, 64'(m_cmd_rem_qpn), 64'(qp_req_rem_qpn));
                chk({tag, "_rkey0"}, 64'(m_cmd_r_key), 64'(qp_req_r_key));
                chk({tag, "_ip0"}, 64'(m_cmd_rem_ip_addr), 64'(qp_req_rem_ip_addr));
            end
            if (i == int'(v.ntr) - 1) begin
                chk({tag, "_addr_last"}, m_cmd_rem_addr, v.exp_addr_last);
                chk({tag, "_psn_last"}, 64'(m_cmd_start_psn), 64'(v.exp_psn_last));
                chk({tag, "_last_flag"}, 64'(m_cmd_last), 64'd1);
                chk({tag, "_imm_last"}, 64'(m_cmd_is_immediate), 64'(v.imm));
            end else begin
                chk({tag, "_last_early"}, 64'(m_cmd_last), 64'd0);
                chk({tag, "_imm_early"}, 64'(m_cmd_is_immediate), 64'd0);
            end
            @(negedge clk);
        end
        chk({tag, "_wr_done"}, 64'(wr_done), 64'd1);
        chk({tag, "_valid_after"}, 64'(m_cmd_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(wr_done), 64'd0);
        chk({tag, "_ready_back"}, 64'(s_wr_ready), 64'd1);
    endtask

    initial begin
        int first_k;
        int pulses;
        int seen_valid;
        vec_t v;

        //           qpn       type imm pmtu len      ntr    off                    ctx_addr                ctx_psn    npk    addr0                  psn0       addr_last              psn_last
        vecs[0] = '{24'h100, 1'b0, 1'b0, 3'd3, 32'd5000, 32'd2, 64'h100, 64'h1000_0000, 24'hFFFFFE, 25'd3, 64'h1000_0100, 24'hFFFFFE, 64'h1000_1488, 24'h000001};
        vecs[1] = '{24'h101, 1'b1, 1'b1, 3'd0, 32'd0,    32'd1, 64'h0,   64'h2000,      24'h000010, 25'd1, 64'h2000,      24'h000010, 64'h2000,      24'h000010};
        vecs[2] = '{24'h103, 1'b0, 1'b1, 3'd7, 32'd4097, 32'd3, 64'h800, 64'hFFFF_FFFF_FFFF_F000, 24'h000100, 25'd2, 64'hFFFF_FFFF_FFFF_F800, 24'h000100, 64'h0000_0000_0000_1802, 24'h000104};
        vecs[3] = '{24'h102, 1'b1, 1'b0, 3'd0, 32'd257,  32'd1, 64'h200, 64'hFFFF_FFFF_FFFF_FF00, 24'hABCDEF, 25'd2, 64'h100, 24'hABCDEF, 64'h100, 24'hABCDEF};
        vecs[4] = '{24'h100, 1'b0, 1'b0, 3'd4, 32'd4096, 32'd2, 64'h0,   64'h4000,      24'hFFFFFF, 25'd1, 64'h4000,      24'hFFFFFF, 64'h5000,      24'h000000};

        rst = 1'b1;
        s_wr_valid = 1'b0;
        s_tx_type = 1'b0;
        s_is_immediate = 1'b0;
        s_loc_qpn = 24'h0;
        s_rem_addr_offset = 64'h0;
        s_dma_length = 32'h0;
        s_n_transfers = 32'h0;
        qp_req_r_key = 32'hCAFE_0001;
        qp_req_rem_qpn = 24'h00A001;
        qp_req_rem_psn = 24'h0;
        qp_req_rem_ip_addr = 32'h0A00_0001;
        qp_req_rem_addr = 64'h0;
        m_cmd_ready = 1'b1;
        stop_transfer = 1'b0;
        pmtu = 3'd0;

        repeat (3) @(negedge clk);
        chk("rst_wr_ready", 64'(s_wr_ready), 64'd1);
        chk("rst_cmd_valid", 64'(m_cmd_valid), 64'd0);
        chk("rst_ctx_req", 64'(qp_context_req), 64'd0);
        chk("rst_ctx_qpn", 64'(qp_local_qpn_req), 64'd0);
        chk("rst_cmd_addr", m_cmd_rem_addr, 64'd0);
        chk("rst_done_err_busy", {61'd0, wr_done, wr_error, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            qp_req_r_key       = 32'hCAFE_0000 + 32'(i);
            qp_req_rem_qpn     = 24'h00A000 + 24'(i);
            qp_req_rem_ip_addr = 32'h0A00_0000 + 32'(i);
            run_wr(vecs[i], $sformatf("v%0d", i));
        end

        // Zero transfers: context fetched, no command, wr_done the cycle after context valid.
        v = vecs[1];
        v.ntr = 32'd0;
        drive_wr(v);
        first_k = -1;
        seen_valid = 0;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            s_wr_valid = 1'b0;
            if (m_cmd_valid) seen_valid++;
            if (wr_done) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("n0_done_cycle", 64'(first_k), 64'd4);
        chk("n0_done_pulses", 64'(pulses), 64'd1);
        chk("n0_no_cmd", 64'(seen_valid), 64'd0);

        // Out-of-window QPN: no context, wr_error CTX_TIMEOUT+1 cycles after CTX_REQ (k=1).
        v = vecs[0];
        v.qpn = 24'h200;
        drive_wr(v);
        first_k = -1;
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            s_wr_valid = 1'b0;
            if (wr_error) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (wr_done) pulses += 100;
        end
        chk("to_err_cycle", 64'(first_k), 64'd10);
        chk("to_err_pulses", 64'(pulses), 64'd1);
        chk("to_ready_back", 64'(s_wr_ready), 64'd1);

        // Backpressure with stop_transfer toggling while the first command is held.
        m_cmd_ready = 1'b0;
        drive_wr(vecs[0]);
        @(negedge clk);
        s_wr_valid = 1'b0;
        seen_valid = 0;
        while (!m_cmd_valid && seen_valid < 20) begin
            @(negedge clk);
            seen_valid++;
        end
        chk("bp_first_valid", 64'(m_cmd_valid), 64'd1);
        for (int j = 0; j < 10; j++) begin
            stop_transfer = j[0];
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", j), 64'(m_cmd_valid), 64'd1);
            chk($sformatf("bp_hold_addr_%0d", j), m_cmd_rem_addr, 64'h1000_0100);
            chk($sformatf("bp_hold_psn_%0d", j), 64'(m_cmd_start_psn), 64'hFFFFFE);
        end
        stop_transfer = 1'b1;
        m_cmd_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("bp_stop_no_valid_%0d", j), 64'(m_cmd_valid), 64'd0);
        end
        stop_transfer = 1'b0;
        #1;
        chk("bp_cmd1_valid", 64'(m_cmd_valid), 64'd1);
        chk("bp_cmd1_addr", m_cmd_rem_addr, 64'h1000_1488);
        chk("bp_cmd1_psn", 64'(m_cmd_start_psn), 64'h000001);
        chk("bp_cmd1_last", 64'(m_cmd_last), 64'd1);
        @(negedge clk);
        chk("bp_wr_done", 64'(wr_done), 64'd1);
        @(negedge clk);

        // Reset during ISSUE after cmd0 has been accepted.
        v = '{24'h101, 1'b0, 1'b0, 3'd0, 32'd100, 32'd3, 64'h0, 64'h8000, 24'h000050,
              25'd1, 64'h8000, 24'h000050, 64'h80C8, 24'h000052};
        drive_wr(v);
        @(negedge clk);
        s_wr_valid = 1'b0;
        seen_valid = 0;
        while (!m_cmd_valid && seen_valid < 20) begin
            @(negedge clk);
            seen_valid++;
        end
        chk("rs_cmd0_addr", m_cmd_rem_addr, 64'h8000);
        @(negedge clk);
        m_cmd_ready = 1'b0;
        chk("rs_cmd1_addr", m_cmd_rem_addr, 64'h8064);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cmd_ready = 1'b1;
        chk("rs_valid_dropped", 64'(m_cmd_valid), 64'd0);
        chk("rs_no_done_err", {62'd0, wr_done, wr_error}, 64'd0);
        chk("rs_ready_idle", 64'(s_wr_ready), 64'd1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wr_done || wr_error || m_cmd_valid) pulses++;
        end
        chk("rs_quiet_after", 64'(pulses), 64'd0);
        v = '{24'h101, 1'b0, 1'b0, 3'd0, 32'd100, 32'd1, 64'h0, 64'h9000, 24'h000200,
              25'd1, 64'h9000, 24'h000200, 64'h9000, 24'h000200};
        run_wr(v, "rs_fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
